bayer_gray_conv: RTL and testbench

BAYER_GRAY_CONV -- requirements
Module: bayer_gray_conv

---
 rtl/img_pkg.sv | 16 +
 rtl/line_buffer_ram.sv | 30 +++
 rtl/bayer_gray_conv.sv | 167 ++++++++++++++++
 tb/tb_bayer_gray_conv.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared image-path types and default geometry for the Bayer conversion blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package img_pkg;

    typedef enum logic {
        MODE_GRAY = 1'b0,
        MODE_RAW  = 1'b1
    } mode_e;

    localparam int DEF_DATA_W  = 12;
    localparam int DEF_LINE_W  = 640;
    localparam int DEF_FRAME_H = 480;
    localparam int OUT_W       = 16;

endpackage

// File: rtl/line_buffer_ram.sv
// Simple dual-port line store, one write and one registered read per cycle.
// Latency: 1 cycle from rd_en to rd_data; a same-address write returns the old word.
// Backpressure: none; rd_data holds while rd_en is low.
module line_buffer_ram #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 640,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port and registered read port; no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/bayer_gray_conv.sv
// Bayer 2x2 binning to grayscale (GRAY) or raw passthrough (RAW), with frame-end pulse.
// Latency: 2 cycles from qualifying input beat to out_valid in both modes.
// Backpressure: none; the stream advances only on in_valid and the pipeline holds otherwise.
module bayer_gray_conv
    import img_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int LINE_W  = DEF_LINE_W,
    parameter int FRAME_H = DEF_FRAME_H
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] in_data,
    input  logic [11:0]       in_x,
    input  logic [15:0]       in_y,
    input  logic              mode,
    output logic              out_valid,
    output logic [15:0]       out_data,
    output logic              frame_done
);

    localparam int ADDR_W = $clog2(LINE_W);
    localparam int CNT_W  = $clog2(LINE_W * FRAME_H + 1);
    localparam logic [CNT_W-1:0] GRAY_TOTAL = CNT_W'((LINE_W / 2) * (FRAME_H / 2));
    localparam logic [CNT_W-1:0] RAW_TOTAL  = CNT_W'(LINE_W * FRAME_H);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LINE_W - 1);

    // Only the parity of the coordinates matters for Bayer quad selection.
    logic unused_bits;
    assign unused_bits = ^{in_x[11:1], in_y[15:1]};

    // Input-side control.
    logic              pix_en;
    logic              sof_beat;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] addr;
    logic              line_vld;
    mode_e             mode_q;
    mode_e             eff_mode;
    logic              qualify;

    // A reset cycle also blocks RAM writes and window updates so nothing from it leaks.
    assign pix_en   = in_valid && !rst;
    assign sof_beat = pix_en && in_sof;
    assign addr     = sof_beat ? '0 : wr_ptr;
    // The SOF beat itself already belongs to the new frame's mode.
    assign eff_mode = sof_beat ? mode_e'(mode) : mode_q;
    assign qualify  = (eff_mode == MODE_RAW) ||
                      (in_x[0] && in_y[0] && line_vld && !sof_beat);

    // Stage 1 window and control.
    logic [DATA_W-1:0] prev_x;
    logic [DATA_W-1:0] prev_xm1;
    logic [DATA_W-1:0] cur_x;
    logic [DATA_W-1:0] cur_xm1;
    logic              s1_vld;
    logic              s1_sof;
    logic              s1_raw;

    // Stage 2 frame accounting.
    logic [CNT_W-1:0]  out_cnt;
    logic              closed;
    logic [CNT_W-1:0]  cnt_base;
    logic [CNT_W-1:0]  cnt_inc;
    logic              closed_base;
    logic [CNT_W-1:0]  total;
    logic              hit;
    logic [DATA_W+1:0] win_sum;
    logic [DATA_W-1:0] gray_pix;

    line_buffer_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (LINE_W),
        .ADDR_W (ADDR_W)
    ) u_line_buf (
        .clk     (clk),
        .wr_en   (pix_en),
        .wr_addr (addr),
        .wr_data (in_data),
        .rd_en   (pix_en),
        .rd_addr (addr),
        .rd_data (prev_x)
    );

    // Write pointer, line-valid flag and per-frame mode latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            line_vld <= 1'b0;
            mode_q   <= MODE_GRAY;
        end else if (pix_en) begin
            mode_q <= eff_mode;
            if (addr == LAST_ADDR) begin
                wr_ptr <= '0;
            end else begin
                wr_ptr <= addr + ADDR_W'(1);
            end
            if (sof_beat) begin
                line_vld <= 1'b0;
            end else if (addr == LAST_ADDR) begin
                line_vld <= 1'b1;
            end
        end
    end

    // Stage 1 control: valid drops on idle cycles so gaps never emit output.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_sof <= 1'b0;
            s1_raw <= 1'b0;
        end else begin
            s1_vld <= pix_en && qualify;
            s1_sof <= sof_beat;
            s1_raw <= (eff_mode == MODE_RAW);
        end
    end

    // Stage 1 window pixels: shift in the new column only on real beats.
    always_ff @(posedge clk) begin
        if (pix_en) begin
            cur_xm1  <= cur_x;
            cur_x    <= in_data;
            prev_xm1 <= prev_x;
        end
    end

    assign win_sum  = {2'b00, prev_xm1} + {2'b00, prev_x} + {2'b00, cur_xm1} + {2'b00, cur_x};
    assign gray_pix = win_sum[DATA_W+1:2];

    // An SOF in stage 1 restarts the count so late outputs of the old frame stay in the old frame.
    assign cnt_base    = s1_sof ? '0 : out_cnt;
    assign closed_base = s1_sof ? 1'b0 : closed;
    assign cnt_inc     = cnt_base + CNT_W'(1);
    assign total       = s1_raw ? RAW_TOTAL : GRAY_TOTAL;
    assign hit         = s1_vld && !closed_base && (cnt_inc == total);

    // Stage 2: registered outputs and frame-completion tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            frame_done <= 1'b0;
            out_cnt    <= '0;
            closed     <= 1'b0;
        end else begin
            out_valid  <= s1_vld;
            frame_done <= hit;
            if (s1_vld) begin
                out_data <= OUT_W'(s1_raw ? cur_x : gray_pix);
                if (hit) begin
                    out_cnt <= '0;
                    closed  <= 1'b1;
                end else begin
                    out_cnt <= closed_base ? cnt_base : cnt_inc;
                    closed  <= closed_base;
                end
            end else if (s1_sof) begin
                out_cnt <= '0;
                closed  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bayer_gray_conv.sv
// Scoreboard bench for bayer_gray_conv on an 8x4 frame geometry.
// Latency: expects every output exactly 2 cycles after its qualifying beat.
// Backpressure: none exercised; gaps come from in_valid idles and resets.
module tb_bayer_gray_conv;

    localparam int DATA_W  = 12;
    localparam int LINE_W  = 8;
    localparam int FRAME_H = 4;
    localparam int GRAY_TOT = (LINE_W / 2) * (FRAME_H / 2);
    localparam int RAW_TOT  = LINE_W * FRAME_H;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_sof;
    logic [DATA_W-1:0] in_data;
    logic [11:0]       in_x;
    logic [15:0]       in_y;
    logic              mode;
    logic              out_valid;
    logic [15:0]       out_data;
    logic              frame_done;

    bayer_gray_conv #(
        .DATA_W  (DATA_W),
        .LINE_W  (LINE_W),
        .FRAME_H (FRAME_H)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_data    (in_data),
        .in_x       (in_x),
        .in_y       (in_y),
        .mode       (mode),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    logic rst_q;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    typedef struct packed {
        int          cyc;
        logic [15:0] data;
        logic        done;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic [15:0] last_dat = '0;

    // Reference model state: beats since sync, latched mode, frame count.
    int          m_beats  = 0;
    logic        m_mode   = 1'b0;
    int          m_cnt    = 0;
    bit          m_closed = 1'b0;
    logic [11:0] hist [LINE_W+2];
    logic [11:0] img  [64];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got 0x%0h want 0x%0h", tag, cyc, act, exp);
        end
    endtask

    // One input cycle; the model predicts output and frame_done for valid beats.
    task automatic drive(input logic v, input logic s, input logic [11:0] d,
                         input int x, input int y, input logic md);
        logic qual;
        logic done;
        logic [15:0] val;
        int   sum;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = v;
        in_sof   = s;
        in_data  = d;
        in_x     = x[11:0];
        in_y     = y[15:0];
        mode     = md;
        if (v) begin
            if (s) begin
                m_beats  = 0;
                m_cnt    = 0;
                m_closed = 1'b0;
                m_mode   = md;
            end
            for (int i = LINE_W + 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = d;
            sum = int'(hist[LINE_W+1]) + int'(hist[LINE_W]) + int'(hist[1]) + int'(hist[0]);
            if (m_mode) begin
                qual = 1'b1;
                val  = {4'h0, d};
            end else begin
                qual = x[0] && y[0] && (m_beats >= LINE_W);
                val  = 16'(sum >> 2);
            end
            m_beats++;
            if (qual) begin
                m_cnt++;
                done = 1'b0;
                if (!m_closed && m_cnt == (m_mode ? RAW_TOT : GRAY_TOT)) begin
                    done     = 1'b1;
                    m_closed = 1'b1;
                    m_cnt    = 0;
                end
                sbq.push_back('{cyc: cyc + 2, data: val, done: done});
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, 0, 0, 1'b0);
    endtask

    // Reset cycles with in_valid toggling; outputs not yet visible at the reset edge are dropped.
    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rst      = 1'b1;
            in_valid = (i % 2 == 0);
            in_sof   = 1'b0;
            in_data  = 12'hABC;
            mode     = 1'b1;
            while (sbq.size() > 0 && sbq[$].cyc >= cyc + 1) void'(sbq.pop_back());
        end
        m_beats  = 0;
        m_mode   = 1'b0;
        m_cnt    = 0;
        m_closed = 1'b0;
    endtask

    // Send frame-relative pixels first..last from img[]; optional gap, mid-frame mode toggle, reset.
    task automatic send_px(input int first, input int last, input bit sof, input logic md,
                           input int gap_at, input int tog_at, input int rst_at);
        logic m;
        for (int p = first; p <= last; p++) begin
            if (p == gap_at) idle(5);
            m = md ^ (tog_at >= 0 && p >= tog_at);
            if (p == rst_at) begin
                do_reset(1);
            end else begin
                drive(1'b1, sof && (p == first), img[p], p % LINE_W, p / LINE_W, m);
            end
        end
    endtask

    // Output monitor: every out_valid beat must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst_q) begin
            check("rst_out_valid", {31'b0, out_valid}, 0);
            check("rst_out_data", {16'b0, out_data}, 0);
            check("rst_frame_done", {31'b0, frame_done}, 0);
            last_dat = '0;
        end else if (out_valid) begin
            if (sbq.size() == 0) begin
                check("spurious_out_valid", {31'b0, out_valid}, 0);
            end else begin
                e = sbq.pop_front();
                check("latency_cycle", cyc, e.cyc);
                check("out_data", {16'b0, out_data}, {16'b0, e.data});
                check("frame_done", {31'b0, frame_done}, {31'b0, e.done});
                last_dat = e.data;
            end
        end else begin
            check("done_without_valid", {31'b0, frame_done}, 0);
            check("out_data_hold", {16'b0, out_data}, {16'b0, last_dat});
        end
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = '0;
        in_x     = '0;
        in_y     = '0;
        mode     = 1'b0;
        for (int i = 0; i < LINE_W + 2; i++) hist[i] = '0;

        do_reset(3);
        idle(2);

        // Constant gray frame.
        for (int i = 0; i < 64; i++) img[i] = 12'h100;
        send_px(0, 31, 1'b1, 1'b0, -1, -1, -1);
        idle(4);

        // Saturated window: no overflow in the 4-pixel sum.
        for (int i = 0; i < 64; i++) img[i] = 12'hFFF;
        img[LINE_W + 1] = 12'hFFD;
        send_px(0, 31, 1'b1, 1'b0, -1, -1, -1);
        idle(3);

        // RAW ramp with mode toggled mid-frame.
        for (int i = 0; i < 64; i++) img[i] = 12'(i);
        send_px(0, 31, 1'b1, 1'b1, -1, 10, -1);
        idle(3);

        // Random gray frame, gapless then with a 5-cycle mid-line gap.
        for (int i = 0; i < 64; i++) img[i] = 12'($urandom_range(0, 4095));
        send_px(0, 31, 1'b1, 1'b0, -1, -1, -1);
        send_px(0, 31, 1'b1, 1'b0, 19, -1, -1);
        idle(3);

        // Resync: SOF re-asserted part-way through a frame.
        send_px(0, 11, 1'b1, 1'b0, -1, -1, -1);
        send_px(0, 31, 1'b1, 1'b0, -1, -1, -1);

        // Beats past the frame total without a new SOF: outputs but no second pulse.
        send_px(16, 31, 1'b0, 1'b0, -1, -1, -1);
        idle(3);

        // Reset at pixel 13 of a frame, then a clean frame.
        for (int i = 0; i < 64; i++) img[i] = 12'($urandom_range(0, 4095));
        send_px(0, 31, 1'b1, 1'b0, -1, -1, 13);
        idle(3);
        send_px(0, 31, 1'b1, 1'b0, -1, -1, -1);

        // RAW frame then extra raw beats past the total.
        send_px(0, 31, 1'b1, 1'b1, -1, -1, -1);
        send_px(0, 7, 1'b0, 1'b1, -1, -1, -1);
        idle(6);

        check("scoreboard_drained", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
